// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : quadrature_decoder
//  Purpose  : Quadrature encoder front end for one biped joint. The block
//             synchronises and glitch-filters the A/B channels and decodes
//             them at x1, x2 or x4 resolution. It keeps a signed position
//             counter that either wraps or saturates, flags illegal (two-bit)
//             transitions, and can optionally measure velocity as the net
//             count over a fixed window.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1      single clock domain
//    reset     in   1      synchronous, active-high
//    quadA     in   1      encoder channel A (asynchronous)
//    quadB     in   1      encoder channel B (asynchronous)
//    zero      in   1      load position with PRESET
//    position  out  CNT_W  signed position
//    dir       out  1      sign of the last counted step (1 = forward)
//    step      out  1      one-cycle pulse per counted step
//    err       out  1      one-cycle pulse per illegal transition
//    err_cnt   out  8      illegal-transition count, saturates at 255
//    velocity  out  VEL_W  signed net count of the last completed window
//    vel_valid out  1      one-cycle pulse when velocity updates
// ----------------------------------------------------------------------------
//  Build option
//    QDEC_VELOCITY_EN : when defined, the velocity window logic is built.
//                       When undefined, velocity and vel_valid are tied to 0.
//  Legal MODE values are 1, 2 and 4; any other value decodes as x4.
// ============================================================================
module quadrature_decoder #(
    parameter int CNT_W      = 16,
    parameter int MODE       = 4,
    parameter int FILT_LEN   = 4,
    parameter int SATURATE   = 0,
    parameter int PRESET     = 0,
    parameter int VEL_W      = 12,
    parameter int VEL_WINDOW = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    quadA,
    input  logic                    quadB,
    input  logic                    zero,
    output logic signed [CNT_W-1:0] position,
    output logic                    dir,
    output logic                    step,
    output logic                    err,
    output logic [7:0]              err_cnt,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    vel_valid
);

    localparam int               c_FCNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] c_PRESET    = CNT_W'(PRESET);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_POS_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] c_POS_MIN   = {1'b1, {(CNT_W-1){1'b0}}};

    // Channel vectors are packed {A,B} throughout.
    logic [1:0]          r_s1;
    logic [1:0]          r_s2;
    logic [1:0]          r_filt;
    logic [1:0]          r_prev;
    logic [c_FCNT_W-1:0] r_fcnt [2];

    logic [CNT_W-1:0]    r_position;
    logic                r_dir;
    logic                r_step;
    logic                r_err;
    logic [7:0]          r_err_cnt;

    logic [1:0]          w_diff;
    logic                w_fwd;
    logic                w_illegal;
    logic                w_a_edge;
    logic                w_count;
    logic [CNT_W-1:0]    w_pos_next;

    // Two-flop synchroniser; deliberately not reset.
    always_ff @(posedge clk) begin
        r_s1 <= {quadA, quadB};
        r_s2 <= r_s1;
    end

    // Per-channel stability filter. During reset filt and prev follow s2 so
    // that releasing reset with the pins high does not look like a step.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                r_filt[i] <= r_s2[i];
                r_fcnt[i] <= '0;
            end else if (r_s2[i] == r_filt[i]) begin
                r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == c_FCNT_LAST) begin
                r_filt[i] <= r_s2[i];
                r_fcnt[i] <= '0;
            end else begin
                r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end
        end
        r_prev <= reset ? r_s2 : r_filt;
    end

    // Forward successor in the 00 -> 10 -> 11 -> 01 -> 00 cycle.
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
    endfunction

    // In every mode the sign of a counted A transition matches its direction
    // in the forward cycle, so one forward test serves x1, x2 and x4.
    always_comb begin
        w_diff    = r_prev ^ r_filt;
        w_fwd     = (r_filt == fwd_next(r_prev));
        w_illegal = &w_diff;
        w_a_edge  = (w_diff == 2'b10);
        w_count   = 1'b0;
        if (MODE == 1) begin
            w_count = w_a_edge & r_filt[1];
        end else if (MODE == 2) begin
            w_count = w_a_edge;
        end else begin
            w_count = ^w_diff;
        end
    end

    always_comb begin
        w_pos_next = r_position;
        if (w_count) begin
            if (w_fwd) begin
                if (!((SATURATE != 0) && (r_position == c_POS_MAX))) begin
                    w_pos_next = r_position + c_ONE;
                end
            end else begin
                if (!((SATURATE != 0) && (r_position == c_POS_MIN))) begin
                    w_pos_next = r_position - c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_position <= c_PRESET;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_step <= w_count;
            r_err  <= w_illegal;
            if (w_count) begin
                r_dir <= w_fwd;
            end
            // zero overrides the count but step/dir above still report it.
            r_position <= zero ? c_PRESET : w_pos_next;
            if (w_illegal && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign position = r_position;
    assign dir      = r_dir;
    assign step     = r_step;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;

`ifdef QDEC_VELOCITY_EN
    localparam int               c_WIN_W    = $clog2(VEL_WINDOW);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(VEL_WINDOW - 1);
    localparam logic [VEL_W-1:0] c_VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic [VEL_W-1:0] c_VEL_MIN  = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic [VEL_W:0]   c_D_POS    = (VEL_W+1)'(1);
    localparam logic [VEL_W:0]   c_D_NEG    = '1;

    logic [c_WIN_W-1:0] r_win;
    logic [VEL_W-1:0]   r_acc;
    logic [VEL_W-1:0]   r_velocity;
    logic               r_vel_valid;
    logic [VEL_W:0]     w_delta;
    logic [VEL_W:0]     w_sum;
    logic [VEL_W-1:0]   w_sat;

    // One guard bit holds the exact sum; the top two bits disagree only when
    // the result has left the VEL_W range, and the guard bit gives its sign.
    always_comb begin
        w_delta = '0;
        if (w_count) begin
            w_delta = w_fwd ? c_D_POS : c_D_NEG;
        end
        w_sum = {r_acc[VEL_W-1], r_acc} + w_delta;
        w_sat = w_sum[VEL_W-1:0];
        if (w_sum[VEL_W] != w_sum[VEL_W-1]) begin
            w_sat = w_sum[VEL_W] ? c_VEL_MIN : c_VEL_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win       <= '0;
            r_acc       <= '0;
            r_velocity  <= '0;
            r_vel_valid <= 1'b0;
        end else if (r_win == c_WIN_LAST) begin
            r_win       <= '0;
            r_acc       <= '0;
            r_velocity  <= w_sat;
            r_vel_valid <= 1'b1;
        end else begin
            r_win       <= r_win + 1'b1;
            r_acc       <= w_sat;
            r_vel_valid <= 1'b0;
        end
    end

    assign velocity  = r_velocity;
    assign vel_valid = r_vel_valid;
`else
    // VEL_WINDOW is always at least 2, so this comparison is constant 0.
    assign velocity  = '0;
    assign vel_valid = (VEL_WINDOW < 0);
`endif

endmodule
`default_nettype wire
